// File: rtl/memory_access_unit.sv
// Load/store sequencer between the execute stage and a single-port
// synchronous word RAM. Sub-word stores run as read-modify-write.
module memory_access_unit #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqIsStore,
    input  logic [2:0]            reqFunct3,
    input  logic [31:0]           reqAddress,
    input  logic [31:0]           reqStoreData,
    output logic                  respValid,
    output logic [31:0]           respLoadData,
    output logic                  respError,
    output logic [1:0]            memMode,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memWriteEnable,
    output logic [31:0]           memWriteData,
    input  logic [31:0]           memReadData
);

    typedef enum logic [1:0] {
        MEM_NOP           = 2'b00,
        MEM_LOAD          = 2'b01,
        MEM_STORE_PRELOAD = 2'b10,
        MEM_STORE         = 2'b11
    } mem_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_PRELOAD,
        S_MERGE,
        S_WRITE,
        S_ERR,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            byte_off_q, byte_off_d;
    logic [31:0]           store_data_q, store_data_d;
    logic                  err_q, err_d;
    logic [31:0]           load_data_q, load_data_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic                  req_illegal;
    logic                  req_misaligned;
    mem_mode_e             mode;
    logic                  write_en;

    // Request legality: funct3 decode per direction and natural alignment.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (reqIsStore) begin
            req_illegal = !(reqFunct3 == 3'b000 || reqFunct3 == 3'b001 ||
                            reqFunct3 == 3'b010);
        end else begin
            req_illegal = !(reqFunct3 == 3'b000 || reqFunct3 == 3'b001 ||
                            reqFunct3 == 3'b010 || reqFunct3 == 3'b100 ||
                            reqFunct3 == 3'b101);
        end
        if (reqFunct3[1:0] == 2'b01 && reqAddress[0]) begin
            req_misaligned = 1'b1;
        end
        if (reqFunct3[1:0] == 2'b10 && reqAddress[1:0] != 2'b00) begin
            req_misaligned = 1'b1;
        end
    end

    // Next-state, datapath and per-phase RAM control.
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        byte_off_d   = byte_off_q;
        store_data_d = store_data_q;
        err_d        = err_q;
        load_data_d  = load_data_q;
        mem_addr_d   = mem_addr_q;
        mode         = MEM_NOP;
        write_en     = 1'b0;
        memWriteData = '0;

        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    funct3_d     = reqFunct3;
                    byte_off_d   = reqAddress[1:0];
                    store_data_d = reqStoreData;
                    err_d        = req_illegal || req_misaligned;
                    if (req_illegal || req_misaligned) begin
                        state_d = S_ERR;
                    end else begin
                        mem_addr_d = reqAddress[ADDR_WIDTH+1:2];
                        if (!reqIsStore) begin
                            state_d = S_READ;
                        end else if (reqFunct3 == 3'b010) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_PRELOAD;
                        end
                    end
                end
            end
            S_READ: begin
                mode    = MEM_LOAD;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                mode = MEM_LOAD;
                case (funct3_q)
                    3'b000: load_data_d = {{24{memReadData[{byte_off_q, 3'b111}]}},
                                           memReadData[{byte_off_q, 3'b000} +: 8]};
                    3'b100: load_data_d = {24'h0, memReadData[{byte_off_q, 3'b000} +: 8]};
                    3'b001: load_data_d = {{16{memReadData[{byte_off_q[1], 4'b1111}]}},
                                           memReadData[{byte_off_q[1], 4'b0000} +: 16]};
                    3'b101: load_data_d = {16'h0, memReadData[{byte_off_q[1], 4'b0000} +: 16]};
                    default: load_data_d = memReadData;
                endcase
                state_d = S_RESP;
            end
            S_PRELOAD: begin
                mode    = MEM_STORE_PRELOAD;
                state_d = S_MERGE;
            end
            S_MERGE: begin
                mode         = MEM_STORE;
                write_en     = 1'b1;
                memWriteData = memReadData;
                if (funct3_q[1:0] == 2'b00) begin
                    memWriteData[{byte_off_q, 3'b000} +: 8] = store_data_q[7:0];
                end else begin
                    memWriteData[{byte_off_q[1], 4'b0000} +: 16] = store_data_q[15:0];
                end
                state_d = S_RESP;
            end
            S_WRITE: begin
                mode         = MEM_STORE;
                write_en     = 1'b1;
                memWriteData = store_data_q;
                state_d      = S_RESP;
            end
            S_ERR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset returns to IDLE with cleared outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            funct3_q     <= '0;
            byte_off_q   <= '0;
            store_data_q <= '0;
            err_q        <= 1'b0;
            load_data_q  <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            byte_off_q   <= byte_off_d;
            store_data_q <= store_data_d;
            err_q        <= err_d;
            load_data_q  <= load_data_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Reset gates the strobes combinationally so an abort mid-store never writes.
    always_comb begin
        reqReady       = reset && (state_q == S_IDLE);
        respValid      = reset && (state_q == S_RESP);
        respError      = reset && (state_q == S_RESP) && err_q;
        memWriteEnable = reset && write_en;
        memMode        = mode;
        memAddress     = mem_addr_q;
        respLoadData   = load_data_q;
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a behavioural synchronous RAM.
module tb_memory_access_unit;

    localparam int unsigned AW = 12;
    localparam logic [1:0] M_NOP = 2'b00;
    localparam logic [1:0] M_LOAD = 2'b01;
    localparam logic [1:0] M_PRE = 2'b10;
    localparam logic [1:0] M_STORE = 2'b11;

    logic          clock;
    logic          reset;
    logic          reqValid;
    logic          reqReady;
    logic          reqIsStore;
    logic [2:0]    reqFunct3;
    logic [31:0]   reqAddress;
    logic [31:0]   reqStoreData;
    logic          respValid;
    logic [31:0]   respLoadData;
    logic          respError;
    logic [1:0]    memMode;
    logic [AW-1:0] memAddress;
    logic          memWriteEnable;
    logic [31:0]   memWriteData;
    logic [31:0]   memReadData;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic          tb_we;
    logic [AW-1:0] tb_waddr;
    logic [31:0]   tb_wdata;
    int            wr_count;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [1:0]    mode_log [0:15];

    int errors;
    int checks;

    memory_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqIsStore    (reqIsStore),
        .reqFunct3     (reqFunct3),
        .reqAddress    (reqAddress),
        .reqStoreData  (reqStoreData),
        .respValid     (respValid),
        .respLoadData  (respLoadData),
        .respError     (respError),
        .memMode       (memMode),
        .memAddress    (memAddress),
        .memWriteEnable(memWriteEnable),
        .memWriteData  (memWriteData),
        .memReadData   (memReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous RAM with a bench-side preload port.
    always @(posedge clock) begin
        if (tb_we) begin
            ram[tb_waddr] <= tb_wdata;
        end else if (memWriteEnable) begin
            ram[memAddress] <= memWriteData;
            wr_count <= wr_count + 1;
            wr_addr  <= memAddress;
            wr_data  <= memWriteData;
        end
        memReadData <= ram[memAddress];
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clock);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(posedge clock);
        #1 tb_we = 1'b0;
    endtask

    // Issues one request and returns cycles from accept edge to respValid.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, output int lat,
                         output logic [31:0] ld, output logic er);
        lat = 99;
        ld = '0;
        er = 1'b0;
        @(negedge clock);
        reqValid = 1'b1;
        reqIsStore = st;
        reqFunct3 = f3;
        reqAddress = addr;
        reqStoreData = data;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        reqFunct3 = 3'b111;
        reqAddress = '1;
        reqStoreData = '1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            mode_log[i] = memMode;
            if (respValid) begin
                lat = i;
                ld = respLoadData;
                er = respError;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", reqReady); end
        checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL reset_respValid got=%b exp=0", respValid); end
        checks++; if (respError !== 1'b0) begin errors++; $display("FAIL reset_respError got=%b exp=0", respError); end
        checks++; if (respLoadData !== 32'h0) begin errors++; $display("FAIL reset_loaddata got=%h exp=0", respLoadData); end
        checks++; if (memWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", memWriteEnable); end
        checks++; if (memAddress !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", memAddress); end
        checks++; if (memWriteData !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", memWriteData); end
        checks++; if (memMode !== M_NOP) begin errors++; $display("FAIL reset_mode got=%b exp=%b", memMode, M_NOP); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", reqReady); end
    endtask

    task automatic test_loads;
        int lat;
        logic [31:0] ld;
        logic er;
        preload(12'd5, 32'h8899AABB);
        issue(1'b0, 3'b000, 32'h15, 32'h0, lat, ld, er);
        checks++; if (ld !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb got=%h exp=FFFFFFAA", ld); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lb_err got=%b exp=0", er); end
        checks++; if (mode_log[1] !== M_LOAD || mode_log[2] !== M_LOAD || mode_log[3] !== M_NOP)
            begin errors++; $display("FAIL load_modes got=%b,%b,%b exp=01,01,00", mode_log[1], mode_log[2], mode_log[3]); end
        issue(1'b0, 3'b100, 32'h17, 32'h0, lat, ld, er);
        checks++; if (ld !== 32'h00000088) begin errors++; $display("FAIL lbu got=%h exp=00000088", ld); end
        issue(1'b0, 3'b001, 32'h16, 32'h0, lat, ld, er);
        checks++; if (ld !== 32'hFFFF8899) begin errors++; $display("FAIL lh got=%h exp=FFFF8899", ld); end
        issue(1'b0, 3'b101, 32'h14, 32'h0, lat, ld, er);
        checks++; if (ld !== 32'h0000AABB) begin errors++; $display("FAIL lhu got=%h exp=0000AABB", ld); end
        issue(1'b0, 3'b010, 32'h14, 32'h0, lat, ld, er);
        checks++; if (ld !== 32'h8899AABB) begin errors++; $display("FAIL lw got=%h exp=8899AABB", ld); end
    endtask

    task automatic test_sub_word_store;
        int lat;
        logic [31:0] ld;
        logic er;
        int wc0;
        preload(12'd2, 32'h11223344);
        wc0 = wr_count;
        issue(1'b1, 3'b000, 32'h09, 32'hFFFFFF5A, lat, ld, er);
        checks++; if (mode_log[1] !== M_PRE || mode_log[2] !== M_STORE || mode_log[3] !== M_NOP)
            begin errors++; $display("FAIL sb_modes got=%b,%b,%b exp=10,11,00", mode_log[1], mode_log[2], mode_log[3]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL sb_write_count got=%0d exp=%0d", wr_count - wc0, 1); end
        checks++; if (wr_addr !== 12'd2 || wr_data !== 32'h11225A44)
            begin errors++; $display("FAIL sb_write got=%h:%h exp=002:11225A44", wr_addr, wr_data); end
        checks++; if (ld !== 32'h8899AABB) begin errors++; $display("FAIL sb_loaddata_held got=%h exp=8899AABB", ld); end
        issue(1'b1, 3'b001, 32'h0A, 32'h0000BEEF, lat, ld, er);
        checks++; if (ram[2] !== 32'hBEEF5A44) begin errors++; $display("FAIL sh_ram got=%h exp=BEEF5A44", ram[2]); end
        checks++; if (wr_count !== wc0 + 2) begin errors++; $display("FAIL sh_write_count got=%0d exp=2", wr_count - wc0); end
    endtask

    task automatic test_word_store;
        int lat;
        logic [31:0] ld;
        logic er;
        int wc0;
        wc0 = wr_count;
        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, lat, ld, er);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL sw_write_count got=%0d exp=1", wr_count - wc0); end
        checks++; if (wr_addr !== 12'd8 || wr_data !== 32'hDEADBEEF)
            begin errors++; $display("FAIL sw_write got=%h:%h exp=008:DEADBEEF", wr_addr, wr_data); end
        checks++; if (mode_log[1] !== M_STORE) begin errors++; $display("FAIL sw_mode got=%b exp=11", mode_log[1]); end
    endtask

    task automatic test_errors;
        int lat;
        logic [31:0] ld;
        logic er;
        int wc0;
        wc0 = wr_count;
        issue(1'b0, 3'b001, 32'h03, 32'h0, lat, ld, er);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL lh_misaligned_err got=%b exp=1", er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL err_latency got=%0d exp=2", lat); end
        checks++; if (mode_log[1] !== M_NOP || mode_log[2] !== M_NOP)
            begin errors++; $display("FAIL err_modes got=%b,%b exp=00,00", mode_log[1], mode_log[2]); end
        checks++; if (ld !== 32'h8899AABB) begin errors++; $display("FAIL err_loaddata_held got=%h exp=8899AABB", ld); end
        issue(1'b0, 3'b011, 32'h00, 32'h0, lat, ld, er);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL illegal_f3_err got=%b exp=1", er); end
        issue(1'b1, 3'b010, 32'h22, 32'h12345678, lat, ld, er);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_misaligned_err got=%b exp=1", er); end
        checks++; if (wr_count !== wc0) begin errors++; $display("FAIL err_no_write got=%0d exp=0", wr_count - wc0); end
    endtask

    task automatic test_wrap;
        int lat;
        logic [31:0] ld;
        logic er;
        preload(12'd4, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h00004010, 32'h0, lat, ld, er);
        checks++; if (ld !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_lw got=%h exp=CAFEF00D", ld); end
    endtask

    task automatic test_back_to_back;
        int n_ready;
        int n_resp;
        logic prev_resp;
        n_ready = 0;
        n_resp = 0;
        prev_resp = 1'b0;
        @(negedge clock);
        reqValid = 1'b1;
        reqIsStore = 1'b0;
        reqFunct3 = 3'b010;
        reqAddress = 32'h14;
        reqStoreData = '0;
        for (int i = 0; i < 16; i++) begin
            if (reqReady) begin
                n_ready++;
                checks++; if (i > 0 && prev_resp !== 1'b1)
                    begin errors++; $display("FAIL b2b_accept_timing cycle=%0d prev_resp=%b exp=1", i, prev_resp); end
            end
            if (respValid) begin
                n_resp++;
                checks++; if (respLoadData !== 32'h8899AABB)
                    begin errors++; $display("FAIL b2b_data got=%h exp=8899AABB", respLoadData); end
            end
            prev_resp = respValid;
            if (i == 15) reqValid = 1'b0;
            else @(negedge clock);
        end
        checks++; if (n_ready !== 4) begin errors++; $display("FAIL b2b_accepts got=%0d exp=4", n_ready); end
        checks++; if (n_resp !== 4) begin errors++; $display("FAIL b2b_resps got=%0d exp=4", n_resp); end
    endtask

    task automatic test_reset_abort;
        int wc0;
        logic saw_we;
        logic saw_resp;
        int lat;
        logic [31:0] ld;
        logic er;
        preload(12'd3, 32'h01020304);
        wc0 = wr_count;
        saw_we = 1'b0;
        saw_resp = 1'b0;
        @(negedge clock);
        reqValid = 1'b1;
        reqIsStore = 1'b1;
        reqFunct3 = 3'b000;
        reqAddress = 32'h0C;
        reqStoreData = 32'h000000AB;
        @(posedge clock);
        #1 reqValid = 1'b0;
        @(negedge clock);
        checks++; if (memMode !== M_PRE) begin errors++; $display("FAIL abort_preload_mode got=%b exp=10", memMode); end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (memMode !== M_STORE) begin errors++; $display("FAIL abort_merge_mode got=%b exp=11", memMode); end
        saw_we = saw_we | memWriteEnable;
        saw_resp = saw_resp | respValid;
        repeat (2) begin
            @(negedge clock);
            saw_we = saw_we | memWriteEnable;
            saw_resp = saw_resp | respValid;
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", reqReady); end
        saw_resp = saw_resp | respValid;
        checks++; if (saw_we !== 1'b0) begin errors++; $display("FAIL abort_we got=%b exp=0", saw_we); end
        checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL abort_resp got=%b exp=0", saw_resp); end
        checks++; if (wr_count !== wc0) begin errors++; $display("FAIL abort_write_count got=%0d exp=0", wr_count - wc0); end
        checks++; if (ram[3] !== 32'h01020304) begin errors++; $display("FAIL abort_ram got=%h exp=01020304", ram[3]); end
        issue(1'b0, 3'b010, 32'h0C, 32'h0, lat, ld, er);
        checks++; if (ld !== 32'h01020304) begin errors++; $display("FAIL abort_reload got=%h exp=01020304", ld); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        wr_count = 0;
        wr_addr = '0;
        wr_data = '0;
        tb_we = 1'b0;
        tb_waddr = '0;
        tb_wdata = '0;
        reset = 1'b0;
        reqValid = 1'b0;
        reqIsStore = 1'b0;
        reqFunct3 = '0;
        reqAddress = '0;
        reqStoreData = '0;
        test_reset();
        test_loads();
        test_sub_word_store();
        test_word_store();
        test_errors();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
Multi-cycle load/store sequencer between the core's execute stage and a single-port synchronous word RAM. It accepts one RV32I load or store per request. Loads get byte lane extraction with sign/zero extension. Sub-word stores run as read-modify-write: a STORE_PRELOAD read followed by a merged STORE write. It drives the MemoryMode_t encoding so that the register-file writeback select (memoryOutputEnable) and the control logic can track memory phase.

Parameters:
ADDR_WIDTH, 12, word-address width of the attached RAM (4096 words = 16 KiB)

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-low; sampled on rising edge of clock
reqValid  in  1  request present
reqReady  out  1  unit idle and able to accept
reqIsStore  in  1  1 = store, 0 = load
reqFunct3  in  3  Funct3_t width/sign code
reqAddress  in  32  byte address
reqStoreData  in  32  store source (rs2)
respValid  out  1  one-cycle completion pulse
respLoadData  out  32  extended load result; held until next load completes
respError  out  1  ErrorFlag_t, valid with respValid: misaligned or illegal funct3
memMode  out  2  MemoryMode_t of current phase
memAddress  out  ADDR_WIDTH  RAM word address
memWriteEnable  out  1  RAM write strobe
memWriteData  out  32  RAM write word
memReadData  in  32  RAM read word, valid one cycle after address sampled

Behaviour:
- Reset (reset==0 at edge): state IDLE. respValid=0, respLoadData=0, respError=0, memWriteEnable=0, memAddress=0, memWriteData=0, memMode=NOP. reqReady=0 while reset is low.
- Reset mid-operation aborts with no write. This includes MERGE/WRITE: memWriteEnable is 0 in any cycle where reset is low. No respValid is issued for the aborted request.
- Handshake: accept when reqValid && reqReady at an edge. reqReady=1 only in IDLE. Request fields are latched on accept; inputs are don't-care afterwards.
- Word address = reqAddress[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
- States:
  - IDLE: on accept, go to ERR if illegal/misaligned, else READ (load), WRITE (SW), or PRELOAD (SB/SH).
  - READ: memAddress=wordAddr, memMode=LOAD; go to CAPTURE.
  - CAPTURE: memMode=LOAD. Select lane addr[1:0] (byte) or addr[1] (half), little-endian. Sign-extend LB/LH, zero-extend LBU/LHU. Register into respLoadData. Go to RESP.
  - PRELOAD: memAddress=wordAddr, memMode=STORE_PRELOAD; go to MERGE.
  - MERGE: memMode=STORE, memWriteEnable=1. memWriteData = memReadData with the addressed byte/half replaced by reqStoreData[7:0]/[15:0]. Go to RESP.
  - WRITE: memMode=STORE, memWriteEnable=1, memWriteData=reqStoreData. Go to RESP.
  - ERR: no RAM access, memMode=NOP. Go to RESP with respError=1.
  - RESP: respValid=1, memMode=NOP; go to IDLE.
- respError=0 for successful accesses. respLoadData is unchanged by stores and errors.
- Latency from accept edge to the respValid cycle: load 3, SW 2, SB/SH 3, error 2.
- Back-to-back issue: a new request is accepted in the cycle after RESP.
- memWriteEnable is asserted only in MERGE/WRITE, exactly one cycle per store. memAddress holds its last value outside READ/PRELOAD/MERGE/WRITE.

Test Plan:
- RAM[5]=0x8899AABB. LB @0x15 → respLoadData=0xFFFFFFAA, respValid in 3rd cycle after accept. LBU @0x17 → 0x00000088.
- RAM[5]=0x8899AABB. LH @0x16 → 0xFFFF8899. LHU @0x14 → 0x0000AABB. LW @0x14 → 0x8899AABB.
- RAM[2]=0x11223344. SB 0xFFFFFF5A @0x09 → memMode sequence STORE_PRELOAD, STORE. One write of 0x11225A44 to word 2. Then SH 0x0000BEEF @0x0A → 0xBEEF5A44.
- SW 0xDEADBEEF @0x20 → single write to word 8, respValid 2nd cycle. LH @0x03 → respError=1, respValid 2nd cycle, no RAM access. Load funct3 011 → respError=1.
- Reset driven low during MERGE of an SB → no memWriteEnable pulse, RAM unchanged, no respValid. reqReady=1 in the first cycle after reset returns high.
- Address wrap: LW @0x00004010 with ADDR_WIDTH=12 → reads word 4. reqValid held high continuously → requests accepted exactly once per RESP→IDLE cycle.
